tlp_frag_reader: RTL and testbench
==================================

# tlp_frag_reader

Downstream read stage of the TX data-fragmentation TLP buffer. It pops TLP data from the buffer one or two 128-bit locations at a time and parses each TLP's first header DW to find the TLP's total size. It then emits the TLP as 256-bit beats with SOP/EOP and per-DW enables to the next TX stage, using a valid/ready handshake. It is the `FRAD_BUFFER`-side consumer of the buffer.

## Interface
Parameters:
- `BUF_WIDTH`, 128: buffer location width (4 DW).
- `OUT_WIDTH`, 256: output beat width (2 locations, 8 DW).
- `COUNT_WIDTH`, 9: width of buffer occupancy count.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `Count`  in  COUNT_WIDTH  number of locations stored in the buffer.
- `rd_data_1`  in  BUF_WIDTH  head location; combinational view, valid when `Count` ≥ 1.
- `rd_data_2`  in  BUF_WIDTH  head+1 location; valid when `Count` ≥ 2.
- `rd_en`  out  1  pop request; the buffer pops on the same clock edge.
- `rd_mode`  out  1  0 = pop 1 location, 1 = pop 2 locations.
- `frag_valid`  out  1  output beat valid.
- `frag_ready`  in  1  downstream accepts the beat.
- `frag_data`  out  OUT_WIDTH  beat data; `rd_data_1` → [127:0], `rd_data_2` → [255:128].
- `frag_sop`  out  1  first beat of a TLP.
- `frag_eop`  out  1  last beat of a TLP.
- `frag_dw_en`  out  8  valid DW mask; bit i covers `frag_data[32i+31:32i]`.

## Operation
- **Location format:** DW0 is in location bits [31:0].
- **Header decode:** done on `rd_data_1` whenever the FSM is in IDLE.
  - `fmt` = DW0[31:29]; fmt[0]=1 → 4DW header, else 3DW; fmt[1]=1 → has payload.
  - `len` = DW0[9:0]; `len`=0 with payload means 1024.
  - `total_dw` (11 b) = hdr_dw + (has payload ? len : 0), range 3..1028.
  - `total_locs` = ceil(total_dw/4), range 1..257 (9 b).
  - `last_n` = ((total_dw−1) mod 8)+1.
- **FSM states:**
  - IDLE: no TLP in progress.
  - SEND: `locs_left` (9 b) locations remain for the current TLP.
- **Load condition:** `load` = (!`frag_valid` || `frag_ready`) && `Count` ≥ `need`.
- **`need`:**
  - IDLE: 2 if `total_locs` ≥ 2, else 1.
  - SEND: 2 if `locs_left` ≥ 2, else 1.
  - In IDLE, `load` additionally requires `Count` ≥ 1.
- **Pop:** `rd_en` = `load`; `rd_mode` = (`need` == 2). Both are combinational and are 0 whenever `load` is 0.
- **On `load`:**
  - Register `frag_data`; upper half is zeroed when `need` = 1.
  - `frag_valid` ← 1.
  - `frag_sop` ← (state == IDLE).
  - `frag_eop` ← (remaining after this pop == 0).
  - `frag_dw_en`:
    - `(1<<last_n)−1` when `frag_eop` is set; `last_n` is latched at SOP.
    - 8'hFF for all other beats.
  - State: IDLE → SEND if `total_locs` > `need`, else stay IDLE; `locs_left` ← `total_locs` − `need`.
  - In SEND, `locs_left` −= `need`; SEND → IDLE when it reaches 0.
- **No load:** if `frag_valid` && `frag_ready`, then `frag_valid` ← 0.
- **Beat packing:** a beat never carries data from two TLPs; the next SOP always starts in the lower half.
- **Cut-through:** a mid-TLP underrun (`Count` < `need`) inserts bubbles. The block never pops a partial pair.

## Timing
- **Reset values** (while `rst_n`=0 at a clock edge): `frag_valid`=0, `frag_sop`=0, `frag_eop`=0, `frag_dw_en`=0, `frag_data`=0, state=IDLE, `locs_left`=0.
  - `rd_en`=0 during reset.
- **Reset mid-TLP:** abandons the TLP. The buffer is reset by its own logic.
- **Latency:** head header location present with `Count` ≥ `need` in cycle N → `frag_valid`=1 in N+1.
- **Throughput:** 1 beat/cycle while `frag_ready`=1 and `Count` is sufficient. There is no bubble between back-to-back TLPs.
- **Backpressure:** while `frag_valid`=1 and `frag_ready`=0, all `frag_*` outputs are held stable and `rd_en`=0.
- **Pop/accept in the same cycle:** when a beat is accepted and a new load occurs in the same cycle, the new beat replaces the old on that edge.

## Test plan
- **3DW MRd:** DW0=32'h0000_0001, `Count`=1 → one beat, `rd_en`=1 / `rd_mode`=0 for one cycle, `frag_sop`=`frag_eop`=1, `frag_dw_en`=8'h07, upper 128 b = 0.
- **4DW MWr, len=4:** DW0=32'h6000_0004, 2 locations → one beat, `rd_mode`=1, `frag_dw_en`=8'hFF, `frag_sop`=`frag_eop`=1.
- **3DW MWr, len=16:** DW0=32'h4000_0010, 19 DW = 5 locations → 3 beats with pops 2, 2, 1; `frag_eop` on beat 3 with `frag_dw_en`=8'h07. A following MRd emits its SOP on the next cycle.
- **Backpressure:** `frag_ready`=0 for 3 cycles after beat 1 of the len=16 TLP → beat 1 held unchanged, `rd_en`=0 throughout; beat 2 appears on the cycle after `frag_ready` rises.
- **Underrun:** mid-TLP with `locs_left`=3 and `Count`=1 → no pop, `frag_valid` drops after acceptance; on `Count`=2, pop 2 then pop 1 with EOP.
- **Max TLP:** DW0=32'h6000_0000 (4DW, len 0 = 1024) → 1028 DW = 257 locations = 129 beats, last beat `frag_dw_en`=8'h0F.
- **Reset mid-TLP:** assert `rst_n`=0 at beat 50 of the max TLP → all outputs go to their reset values and the FSM is in IDLE on the next edge.

Source files
------------

// File: rtl/tlp_frag_reader.sv
// Read stage of the TX fragmentation TLP buffer: pops one or two 128-bit locations per beat,
// sizes each TLP from its first header DW and emits 256-bit beats with SOP/EOP/DW enables.
module tlp_frag_reader #(
    parameter int unsigned BUF_WIDTH   = 128,
    parameter int unsigned OUT_WIDTH   = 256,
    parameter int unsigned COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COUNT_WIDTH-1:0] Count,
    input  logic [BUF_WIDTH-1:0]   rd_data_1,
    input  logic [BUF_WIDTH-1:0]   rd_data_2,
    output logic                   rd_en,
    output logic                   rd_mode,
    output logic                   frag_valid,
    input  logic                   frag_ready,
    output logic [OUT_WIDTH-1:0]   frag_data,
    output logic                   frag_sop,
    output logic                   frag_eop,
    output logic [7:0]             frag_dw_en
);

    localparam int unsigned LOCS_W  = 9;
    localparam int unsigned DW_W    = 11;
    localparam int unsigned LASTN_W = 4;
    localparam int unsigned DWEN_W  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [LOCS_W-1:0]      locs_left_q, locs_left_d;
    logic [LASTN_W-1:0]     last_n_q, last_n_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [DWEN_W-1:0]      dw_en_q, dw_en_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;

    logic [2:0]             hdr_fmt;
    logic [9:0]             hdr_len;
    logic [DW_W-1:0]        pay_dw;
    logic [DW_W-1:0]        total_dw;
    logic [LOCS_W-1:0]      total_locs;
    logic [LASTN_W-1:0]     hdr_last_n;

    logic [LOCS_W-1:0]      cur_locs;
    logic                   need_two;
    logic [COUNT_WIDTH-1:0] need_cnt;
    logic [LOCS_W-1:0]      remaining;
    logic [LASTN_W-1:0]     last_n_sel;
    logic                   load;

    // Header decode of the head location; only meaningful while idle
    always_comb begin
        hdr_fmt    = rd_data_1[31:29];
        hdr_len    = rd_data_1[9:0];
        pay_dw     = '0;
        if (hdr_fmt[1]) begin
            pay_dw = (hdr_len == 10'd0) ? DW_W'(1024) : DW_W'(hdr_len);
        end
        total_dw   = pay_dw + (hdr_fmt[0] ? DW_W'(4) : DW_W'(3));
        total_locs = LOCS_W'((total_dw + DW_W'(3)) >> 2);
        hdr_last_n = LASTN_W'({1'b0, 3'(total_dw - DW_W'(1))}) + LASTN_W'(1);
    end

    // Pop decision; a pair is only popped when both locations are present
    always_comb begin
        cur_locs   = (state_q == ST_IDLE) ? total_locs : locs_left_q;
        need_two   = (cur_locs >= LOCS_W'(2));
        need_cnt   = need_two ? COUNT_WIDTH'(2) : COUNT_WIDTH'(1);
        remaining  = cur_locs - (need_two ? LOCS_W'(2) : LOCS_W'(1));
        last_n_sel = (state_q == ST_IDLE) ? hdr_last_n : last_n_q;
        load       = rst_n && (!valid_q || frag_ready) &&
                     (Count >= need_cnt) && (Count != '0);
        rd_en      = load;
        rd_mode    = load && need_two;
    end

    // Next-state and registered beat outputs
    always_comb begin
        state_d     = state_q;
        locs_left_d = locs_left_q;
        last_n_d    = last_n_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        dw_en_d     = dw_en_q;
        data_d      = data_q;

        if (load) begin
            data_d      = need_two ? {rd_data_2, rd_data_1}
                                   : {{BUF_WIDTH{1'b0}}, rd_data_1};
            valid_d     = 1'b1;
            sop_d       = (state_q == ST_IDLE);
            eop_d       = (remaining == '0);
            dw_en_d     = (remaining == '0)
                          ? DWEN_W'((9'd1 << last_n_sel) - 9'd1)
                          : DWEN_W'(8'hFF);
            locs_left_d = remaining;
            state_d     = (remaining == '0) ? ST_IDLE : ST_SEND;
            if (state_q == ST_IDLE) begin
                last_n_d = hdr_last_n;
            end
        end else if (valid_q && frag_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            locs_left_q <= '0;
            last_n_q    <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            dw_en_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            locs_left_q <= locs_left_d;
            last_n_q    <= last_n_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            dw_en_q     <= dw_en_d;
            data_q      <= data_d;
        end
    end

    assign frag_valid = valid_q;
    assign frag_sop   = sop_q;
    assign frag_eop   = eop_q;
    assign frag_dw_en = dw_en_q;
    assign frag_data  = data_q;

endmodule

// File: tb/tb_tlp_frag_reader.sv
// Scoreboard bench for tlp_frag_reader: a queue-based buffer model feeds the DUT and a
// TLP-level reference model predicts every output beat.
module tb_tlp_frag_reader;

    localparam int unsigned BW = 128;
    localparam int unsigned OW = 256;
    localparam int unsigned CW = 9;

    typedef struct {
        logic [OW-1:0] data;
        logic          sop;
        logic          eop;
        logic [7:0]    dw_en;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] Count;
    logic [BW-1:0] rd_data_1;
    logic [BW-1:0] rd_data_2;
    logic          rd_en;
    logic          rd_mode;
    logic          frag_valid;
    logic          frag_ready;
    logic [OW-1:0] frag_data;
    logic          frag_sop;
    logic          frag_eop;
    logic [7:0]    frag_dw_en;

    tlp_frag_reader #(.BUF_WIDTH(BW), .OUT_WIDTH(OW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Count      (Count),
        .rd_data_1  (rd_data_1),
        .rd_data_2  (rd_data_2),
        .rd_en      (rd_en),
        .rd_mode    (rd_mode),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_data  (frag_data),
        .frag_sop   (frag_sop),
        .frag_eop   (frag_eop),
        .frag_dw_en (frag_dw_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc = -1;
    int drive_cyc = 0;
    bit in_reset = 1'b1;
    bit pop_pend = 1'b0;
    bit pop_two = 1'b0;

    logic [BW-1:0] buf_q[$];
    beat_t         exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference model: split a TLP into locations and predicted beats
    task automatic push_tlp(input logic [31:0] dw0);
        int hdr, pay, tot, nloc, nb, dws;
        logic [BW-1:0] locs[$];
        logic [BW-1:0] loc;
        beat_t b;
        hdr = dw0[29] ? 4 : 3;
        pay = 0;
        if (dw0[30]) pay = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
        tot  = hdr + pay;
        nloc = (tot + 3) / 4;
        for (int i = 0; i < nloc; i++) begin
            loc = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0) loc[31:0] = dw0;
            locs.push_back(loc);
            buf_q.push_back(loc);
        end
        nb = (nloc + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            b.data[BW-1:0]  = locs[2*k];
            b.data[OW-1:BW] = (2*k + 1 < nloc) ? locs[2*k+1] : '0;
            b.sop   = (k == 0);
            b.eop   = (k == nb - 1);
            dws     = b.eop ? (tot - 8*k) : 8;
            b.dw_en = 8'((1 << dws) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_random_tlp();
        logic [2:0] fmt;
        logic [9:0] len;
        fmt = 3'($urandom_range(0, 3));
        len = ($urandom_range(0, 19) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
        push_tlp({fmt, 19'($urandom()), len});
    endtask

    // One cycle of buffer model: apply last pop, present head, sample pop request
    task automatic drive_cycle(input bit rnd);
        int vis, cnt;
        @(negedge clk);
        drive_cyc = cyc;
        if (pop_pend) begin
            void'(buf_q.pop_front());
            if (pop_two) void'(buf_q.pop_front());
        end
        frag_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        vis = (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : 511;
        cnt = buf_q.size();
        if (cnt > vis) cnt = vis;
        Count     = CW'(cnt);
        rd_data_1 = (buf_q.size() >= 1) ? buf_q[0] : '0;
        rd_data_2 = (buf_q.size() >= 2) ? buf_q[1] : '0;
        #1;
        pop_pend = rd_en;
        pop_two  = rd_mode;
        if (rd_en) begin
            checks++;
            if (int'(Count) < (rd_mode ? 2 : 1)) begin
                errors++;
                $display("FAIL pop_underflow: Count %0d rd_mode %0b", Count, rd_mode);
            end
        end
    endtask

    task automatic drain(input bit rnd, input int n_rand, input string name);
        int n = 0;
        int guard = 0;
        while ((n < n_rand || exp_q.size() != 0) && guard < 40000) begin
            if (n < n_rand && buf_q.size() < 64) begin
                push_random_tlp();
                n++;
            end
            drive_cycle(rnd);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: scoreboard compare, hold-under-backpressure and no-pop-while-stalled checks
    initial begin
        beat_t e;
        beat_t p;
        bit prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset || !rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(frag_valid === 1'b1 && frag_data === p.data && frag_sop === p.sop &&
                          frag_eop === p.eop && frag_dw_en === p.dw_en)) begin
                        errors++;
                        $display("FAIL hold: got v%0b s%0b e%0b en%h expected v1 s%0b e%0b en%h",
                                 frag_valid, frag_sop, frag_eop, frag_dw_en, p.sop, p.eop, p.dw_en);
                    end
                end
                if (frag_valid && frag_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: got unexpected beat sop %0b eop %0b, expected none",
                                 frag_sop, frag_eop);
                    end else begin
                        e = exp_q.pop_front();
                        if (frag_data !== e.data || frag_sop !== e.sop ||
                            frag_eop !== e.eop || frag_dw_en !== e.dw_en) begin
                            errors++;
                            $display("FAIL beat: got s%0b e%0b en%h d%h expected s%0b e%0b en%h d%h",
                                     frag_sop, frag_eop, frag_dw_en, frag_data,
                                     e.sop, e.eop, e.dw_en, e.data);
                        end
                    end
                    n_acc++;
                    last_acc_cyc = cyc;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                end
                if (frag_valid && !frag_ready) begin
                    checks++;
                    if (rd_en !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_pop: got rd_en %0b expected 0", rd_en);
                    end
                end
                prev_stall = frag_valid && !frag_ready;
                p.data  = frag_data;
                p.sop   = frag_sop;
                p.eop   = frag_eop;
                p.dw_en = frag_dw_en;
            end
        end
    end

    initial begin
        int start_cyc;
        int base;
        int guard;

        // Reset with a poppable head present: nothing may be popped
        rst_n      = 1'b0;
        frag_ready = 1'b1;
        Count      = CW'(2);
        rd_data_1  = 128'h6000_0004;
        rd_data_2  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", OW'(frag_valid), '0);
        chk("reset_sop",   OW'(frag_sop),   '0);
        chk("reset_eop",   OW'(frag_eop),   '0);
        chk("reset_dw_en", OW'(frag_dw_en), '0);
        chk("reset_data",  frag_data,       '0);
        chk("reset_rd_en", OW'(rd_en),      '0);
        Count = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Directed TLPs back to back, full buffer, no backpressure
        push_tlp(32'h0000_0001);
        push_tlp(32'h6000_0004);
        push_tlp(32'h4000_0010);
        push_tlp(32'h0000_0001);
        push_tlp(32'h6000_0000);
        first_acc_cyc = -1;
        drive_cycle(1'b0);
        start_cyc = drive_cyc;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            drive_cycle(1'b0);
            guard++;
        end
        chk("directed_drain",   OW'(exp_q.size()),  '0);
        chk("first_latency",    OW'(first_acc_cyc), OW'(start_cyc + 1));
        chk("no_bubble_stream", OW'(last_acc_cyc),  OW'(start_cyc + 135));

        // Random TLPs with backpressure and underruns
        drain(1'b1, 80, "random");

        // Reset in the middle of a max-size TLP
        push_tlp(32'h6000_0000);
        base  = n_acc;
        guard = 0;
        while (n_acc < base + 50 && guard < 1000) begin
            drive_cycle(1'b0);
            guard++;
        end
        chk("reach_beat50", OW'(n_acc >= base + 50), OW'(1));
        @(negedge clk);
        if (pop_pend) begin
            void'(buf_q.pop_front());
            if (pop_two) void'(buf_q.pop_front());
        end
        pop_pend   = 1'b0;
        rst_n      = 1'b0;
        in_reset   = 1'b1;
        frag_ready = 1'b1;
        Count      = CW'(buf_q.size() > 511 ? 511 : buf_q.size());
        rd_data_1  = buf_q[0];
        rd_data_2  = buf_q[1];
        #1;
        chk("midreset_rd_en", OW'(rd_en), '0);
        @(negedge clk);
        #1;
        chk("midreset_valid", OW'(frag_valid), '0);
        chk("midreset_sop",   OW'(frag_sop),   '0);
        chk("midreset_eop",   OW'(frag_eop),   '0);
        chk("midreset_dw_en", OW'(frag_dw_en), '0);
        chk("midreset_data",  frag_data,       '0);
        buf_q.delete();
        exp_q.delete();
        Count    = '0;
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Recovery: the FSM must start from IDLE on fresh TLPs
        push_tlp(32'h4000_0010);
        push_tlp(32'h0000_0001);
        drain(1'b1, 10, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
